// File: rtl/lc3b_pipe_stage.sv
// LC-3b pipeline stage register: valid/ready handshake, flush to bubble, saturating stall counter.
// Optional 2-entry skid buffer with registered in_ready when LC3B_PIPE_SKID_EN is defined.
module lc3b_pipe_stage #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    input  logic                  flush,
    input  logic                  stall_cnt_clr,
    output logic [15:0]           stall_cnt
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic                  accept;
    logic                  out_xfer;
    logic [15:0]           stall_q;

    assign accept   = in_valid && in_ready;
    assign out_xfer = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Bubbles carry no control so downstream write-enables stay quiet.
    assign out_ctrl  = main_valid ? main_ctrl : '0;

`ifdef LC3B_PIPE_SKID_EN
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;

    // skid_valid is a register, so in_ready has no path from out_ready.
    assign in_ready = reset_n && !flush && !skid_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end
        end
    end
`else
    assign in_ready = reset_n && !flush && (out_ready || !main_valid);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: doc/lc3b_pipe_stage.md
# lc3b_pipe_stage

Parametrised pipeline stage register for the LC-3b datapath, the general successor to the fixed per-stage latches between IF/ID/EX/MEM/WB. It carries an arbitrary data payload and a control bundle with a valid/ready handshake, supports stall back-pressure and flush (bubble insertion), and zeroes control on bubbles so that downstream write-enables never fire spuriously. An optional 2-entry skid buffer registers `in_ready` to break the ready path between stages. A saturating stall counter supports performance debug.

## Interface
- `DATA_WIDTH`, default 64: payload width (PC, ALU result, address, store data, ...); unaffected by flush.
- `CTRL_WIDTH`, default 8: control bits (load_regfile, load_cc, mem_read, mem_write, mux selects); forced to 0 whenever the output is not valid.
- `clk  in  1`: sole clock, rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `in_valid  in  1`: upstream presents a transfer.
- `in_ready  out  1`: stage accepts a transfer this cycle.
- `in_data  in  DATA_WIDTH`: upstream payload.
- `in_ctrl  in  CTRL_WIDTH`: upstream control.
- `out_valid  out  1`: stage holds a valid transfer.
- `out_ready  in  1`: downstream accepts this cycle.
- `out_data  out  DATA_WIDTH`: payload of the head entry.
- `out_ctrl  out  CTRL_WIDTH`: control of the head entry; 0 when `out_valid`=0.
- `flush  in  1`: discards all held entries and any input this cycle.
- `stall_cnt_clr  in  1`: clears `stall_cnt`.
- `stall_cnt  out  16`: count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- A transfer occurs on an input edge when `in_valid && in_ready`, and on an output edge when `out_valid && out_ready`. Order is preserved and no entry is duplicated or dropped except by flush.
- Main entry: `main_valid`, `main_data`, `main_ctrl`. `out_valid`=`main_valid`, `out_data`=`main_data`, and `out_ctrl`=`main_valid ? main_ctrl : 0`.
- Base mode (no skid): `in_ready` = `reset_n && !flush && (out_ready || !main_valid)`, which is combinational from `out_ready`. On an accepted input, main loads the input. Otherwise, on an output transfer `main_valid` clears. Otherwise main holds.
- Flush: on the next edge every valid bit clears. `in_ready` is 0 during the flush cycle, so no input is captured. An output transfer in the same cycle still counts as delivered downstream. `main_data` is not cleared.
- Stall counter: increments on each edge where `out_valid && !out_ready`, saturates at 0xFFFF, and does not wrap. `stall_cnt_clr` clears it and has priority over increment. Flush does not clear it.
- Reset (reset_n=0 at an edge): all valid bits go to 0, `main_data`/`main_ctrl` go to 0, and `stall_cnt` goes to 0. While `reset_n`=0, `in_ready`=0.

## Timing
- Latency: a transfer accepted at edge N is visible on `out_*` after edge N, in both modes.
- Throughput: one transfer per cycle with `out_ready` held at 1.
- Outputs after reset: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `stall_cnt`=0. `in_ready`=1 in the first cycle after `reset_n` rises (base mode requires `flush`=0).
- Flush and reset take effect at the same edge they are sampled. Reset has priority over flush, and flush has priority over load.

## Configuration
- `LC3B_PIPE_SKID_EN` defined: adds a skid entry (`skid_valid/data/ctrl`), and `in_ready` becomes a register: `in_ready` = `!skid_valid` (0 in reset and in the flush cycle).
  - Accept with main empty, or with main draining: the input goes to main (if skid is empty).
  - Accept while main is held (`out_ready`=0): the input goes to skid.
  - Output transfer with skid valid: skid moves to main, and skid clears unless refilled.
  - Capacity is 2 entries. Flush clears both valid bits.
- Undefined: base mode only, with a single entry and combinational `in_ready`. No skid state is synthesised.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `in_valid`=1 and data 0xAAAA -> `out_valid`=0, `out_ctrl`=0, `stall_cnt`=0, `in_ready`=0. After release, `in_ready`=1.
- Streaming: send data 1..8 with ctrl 0x5 back-to-back and `out_ready`=1 -> `out_data` is 1..8 one cycle later, one per cycle, with `out_ctrl`=0x5.
- Back-pressure: set `out_ready`=0 for 4 cycles mid-stream -> output holds with no loss or duplication and `stall_cnt` increases by 4. With skid: exactly 2 entries accepted, then `in_ready`=0 after one cycle. Base: `in_ready`=0 in the same cycle.
- Flush with 2 entries held (skid) and `in_valid`=1 -> `in_ready`=0 that cycle, `out_valid`=0 and `out_ctrl`=0 next cycle, and the flushed values never appear at the output.
- Saturation/clear: hold a stall for 70000 cycles -> `stall_cnt`=0xFFFF. Assert `stall_cnt_clr` with the stall ongoing -> 0 next cycle, then 1.
